// File: rtl/sn74ls194_seq_pkg.sv
// Shared types for the sn74ls194 sequencer: FSM states, '194 mode codes,
// captured request bundle and a one-step model of the driven '194.
package sn74ls194_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_INH = 2'b00,
    M_SR  = 2'b01,
    M_SL  = 2'b10,
    M_LD  = 2'b11
  } mode_t;

  typedef struct packed {
    logic rot;
    logic dir;
    logic sin;
  } cfg_t;

  // q[0]=QA .. q[3]=QD; right moves QA->QD, left moves QD->QA
  function automatic logic [3:0] ls194_next(
    input mode_t      m,
    input logic [3:0] q,
    input logic [3:0] d,
    input logic       r,
    input logic       l
  );
    logic [3:0] n;
    n = q;
    unique case (m)
      M_SR:    n = {q[2:0], r};
      M_SL:    n = {l, q[3:1]};
      M_LD:    n = d;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sn74ls194_seq_if.sv
// Pin bundle between the sequencer and one sn74ls194.
// master: mode s1/s0, data d, serial r/l out; q back in.
interface sn74ls194_seq_if;
  logic       s1;
  logic       s0;
  logic [3:0] d;
  logic       r;
  logic       l;
  logic [3:0] q;

  modport master (
    output s1, s0, d, r, l,
    input  q
  );

  modport slave (
    input  s1, s0, d, r, l,
    output q
  );
endinterface

// File: rtl/sn74ls194_seq_cnt.sv
// Loadable down counter for the shift step count.
// clk/clr, load+val, dec; cnt value, zero and last (cnt==1) flags.
module sn74ls194_seq_cnt #(
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic            dec,
  input  logic [CNTW-1:0] val,
  output logic [CNTW-1:0] cnt,
  output logic            zero,
  output logic            last
);

  assign zero = (cnt == '0);
  assign last = (cnt == CNTW'(1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/sn74ls194_seq.sv
// Sequencer for one '194: optional load, N shift/rotate steps, then inhibit.
// clk/clr, request inputs, busy/done status, ls = '194 pin bundle.
module sn74ls194_seq
  import sn74ls194_seq_pkg::*;
#(
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            ld,
  input  logic            rot,
  input  logic            dir,
  input  logic [CNTW-1:0] len,
  input  logic [3:0]      din,
  input  logic            sin,
  output logic            busy,
  output logic            done,
  sn74ls194_seq_if.master ls
);

  state_t          state;
  state_t          state_nxt;
  mode_t           mode_q;
  mode_t           mode_nxt;
  cfg_t            cfg_q;
  cfg_t            cfg_cur;
  logic [3:0]      d_q;
  logic [3:0]      d_nxt;
  logic [3:0]      q_pred;
  logic            r_q;
  logic            r_nxt;
  logic            l_q;
  logic            l_nxt;
  logic            go;
  logic [CNTW-1:0] cnt;
  logic            cnt_zero;
  logic            cnt_last;

  assign go = (state == S_IDLE) && start;

  // a shift entered straight from IDLE uses the live request
  assign cfg_cur = (state == S_IDLE) ? cfg_t'({rot, dir, sin}) : cfg_q;

  // outputs are registered and the '194 acts one edge later, so rotate
  // feedback must come from q as it will be after the pending action
  assign q_pred = ls194_next(mode_q, ls.q, d_q, r_q, l_q);

  assign ls.s1 = mode_q[1];
  assign ls.s0 = mode_q[0];
  assign ls.d  = d_q;
  assign ls.r  = r_q;
  assign ls.l  = l_q;

  sn74ls194_seq_cnt #(
    .CNTW (CNTW)
  ) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .load (go),
    .dec  (state == S_SHIFT),
    .val  (len),
    .cnt  (cnt),
    .zero (cnt_zero),
    .last (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (ld)               state_nxt = S_LOAD;
          else if (len != '0)   state_nxt = S_SHIFT;
          else                  state_nxt = S_DONE;
        end
      end
      S_LOAD:  state_nxt = cnt_zero ? S_DONE : S_SHIFT;
      S_SHIFT: state_nxt = cnt_last ? S_DONE : S_SHIFT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mode_nxt = M_INH;
    d_nxt    = d_q;
    r_nxt    = 1'b0;
    l_nxt    = 1'b0;
    unique case (state_nxt)
      S_LOAD: begin
        mode_nxt = M_LD;
        d_nxt    = din;
      end
      S_SHIFT: begin
        mode_nxt = cfg_cur.dir ? M_SL : M_SR;
        unique case (1'b1)
          cfg_cur.dir && cfg_cur.rot:   l_nxt = q_pred[0];
          cfg_cur.dir && !cfg_cur.rot:  l_nxt = cfg_cur.sin;
          !cfg_cur.dir && cfg_cur.rot:  r_nxt = q_pred[3];
          default:                      r_nxt = cfg_cur.sin;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_IDLE;
      mode_q <= M_INH;
      cfg_q  <= '0;
      d_q    <= '0;
      r_q    <= 1'b0;
      l_q    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      if (go) cfg_q <= cfg_t'({rot, dir, sin});
      d_q    <= d_nxt;
      r_q    <= r_nxt;
      l_q    <= l_nxt;
      busy   <= (state_nxt != S_IDLE);
      done   <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_sn74ls194_seq.sv
// Bench: sequencer driving a behavioural '194; q traces, busy length
// and done pulses compared against an arithmetic shift model.
module tb_sn74ls194_seq;

  localparam int CNTW = 4;

  logic            clk    = 1'b0;
  logic            clr    = 1'b0;
  logic            clr194 = 1'b0;
  logic            start  = 1'b0;
  logic            ld     = 1'b0;
  logic            rot    = 1'b0;
  logic            dir    = 1'b0;
  logic            sin    = 1'b0;
  logic [CNTW-1:0] len    = '0;
  logic [3:0]      din    = '0;
  logic            busy;
  logic            done;
  logic [3:0]      q194;
  logic [3:0]      qm;
  int              n_chk  = 0;
  int              n_fail = 0;

  sn74ls194_seq_if bus ();

  sn74ls194_seq #(
    .CNTW (CNTW)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .ld    (ld),
    .rot   (rot),
    .dir   (dir),
    .len   (len),
    .din   (din),
    .sin   (sin),
    .busy  (busy),
    .done  (done),
    .ls    (bus)
  );

  always #5 clk = ~clk;

  assign bus.q = q194;

  // the driven sn74ls194
  always_ff @(posedge clk or negedge clr194) begin
    if (!clr194) q194 <= 4'h0;
    else begin
      case ({bus.s1, bus.s0})
        2'b01:   q194 <= {q194[2:0], bus.r};
        2'b10:   q194 <= {bus.l, q194[3:1]};
        2'b11:   q194 <= bus.d;
        default: q194 <= q194;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one step in value terms: right doubles (fill enters QA), left halves
  function automatic logic [3:0] step(input logic [3:0] v, input bit right,
                                      input bit r_, input bit s_);
    int vi;
    int fill;
    vi = int'(v);
    if (right) begin
      fill = r_ ? vi / 8 : int'(s_);
      return 4'(((vi * 2) % 16) + fill);
    end
    fill = r_ ? vi % 2 : int'(s_);
    return 4'((vi / 2) + fill * 8);
  endfunction

  task automatic scramble();
    ld  = 1'($urandom);
    rot = 1'($urandom);
    dir = 1'($urandom);
    sin = 1'($urandom);
    len = CNTW'($urandom);
    din = 4'($urandom);
  endtask

  task automatic run_seq(input bit l_, input bit r_, input bit d_,
                         input int n, input logic [3:0] di, input bit s_,
                         input bit hold);
    logic [3:0] tr[$];
    logic [3:0] v;
    int nb;
    int nd;
    logic last_done;
    v = qm;
    tr.push_back(v);
    if (l_) begin
      v = di;
      tr.push_back(v);
    end
    for (int i = 0; i < n; i++) begin
      v = step(v, !d_, r_, s_);
      tr.push_back(v);
    end
    @(negedge clk);
    start = 1'b1;
    ld    = l_;
    rot   = r_;
    dir   = d_;
    len   = CNTW'(n);
    din   = di;
    sin   = s_;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      scramble();
    end
    nb = 0;
    nd = 0;
    last_done = 1'b0;
    while (busy === 1'b1 && nb < 40) begin
      if (nb < tr.size()) chk("trace_q", 32'(q194), 32'(tr[nb]));
      nd += int'(done);
      last_done = done;
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'(int'(l_) + n + 1));
    chk("done_pulses", 32'(nd), 32'd1);
    chk("done_last", 32'(last_done), 32'd1);
    chk("q_final", 32'(q194), 32'(v));
    qm = v;
  endtask

  initial begin
    logic [3:0] v;
    int k;
    int nd;

    // reset state
    #12;
    chk("rst_mode", 32'({bus.s1, bus.s0}), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_rl", 32'({bus.r, bus.l}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q194), 32'd0);
    @(negedge clk);
    clr    = 1'b1;
    clr194 = 1'b1;
    qm     = 4'h0;

    run_seq(1'b1, 1'b0, 1'b0, 0, 4'b0101, 1'b0, 1'b0);
    run_seq(1'b1, 1'b0, 1'b0, 3, 4'b1111, 1'b0, 1'b0);
    run_seq(1'b1, 1'b1, 1'b1, 4, 4'b1001, 1'b0, 1'b0);
    chk("rot_back", 32'(q194), 32'h9);
    run_seq(1'b0, 1'b0, 1'b0, 0, 4'b0000, 1'b1, 1'b0);

    // start held high across the whole sequence
    run_seq(1'b0, 1'b1, 1'b0, 2, 4'b0000, 1'b0, 1'b1);
    chk("hold_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hold_restart", 32'(busy), 32'd1);
    start = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("hold_len2", 32'(k), 32'd3);
    qm = step(step(qm, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0);
    chk("hold_q", 32'(q194), 32'(qm));

    // clear during shift after two steps
    @(negedge clk);
    start = 1'b1;
    ld    = 1'b1;
    rot   = 1'b0;
    dir   = 1'b0;
    len   = CNTW'(7);
    din   = 4'b1011;
    sin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_mode", 32'({bus.s1, bus.s0}), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    v  = step(step(4'b1011, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b1);
    nd = 0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (4) begin
      @(negedge clk);
      nd += int'(done) + int'(busy);
    end
    chk("clr_quiet", 32'(nd), 32'd0);
    chk("clr_q", 32'(q194), 32'(v));
    qm = v;

    // randomized sequences
    repeat (25) begin
      run_seq(1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 15)), 4'($urandom), 1'($urandom),
              1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
